// File: rtl/sirv_gnrl_xinjector_pkg.sv
// Shared constants and helpers for the X-injector and other stress blocks.
// Holds the LFSR polynomial, default seed and poison bit-replication helper.
package sirv_gnrl_xinjector_pkg;

    localparam logic [31:0] XINJ_LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] XINJ_DEFAULT_SEED = 32'hACE1_1234;

    typedef logic [31:0] lfsr_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic lfsr_t xinj_seed_fix(input lfsr_t seed);
        return (seed == 32'h0) ? 32'h1 : seed;
    endfunction

    // Galois step, shifting right; x^32+x^22+x^2+x+1.
    function automatic lfsr_t xinj_lfsr_next(input lfsr_t s);
        return (s >> 1) ^ (s[0] ? XINJ_LFSR_MASK : 32'h0);
    endfunction

    // Poison bit idx of a DW-wide bus: the LFSR value replicated, LSBs first.
    function automatic logic xinj_poison_bit(input lfsr_t s, input int unsigned idx);
        return s[idx % 32];
    endfunction

endpackage

// File: rtl/sirv_gnrl_xinjector_lfsr.sv
// Free-running 32-bit Galois LFSR, advances every cycle out of reset.
// Shared by the X-injector and other stress blocks.
module sirv_gnrl_lfsr32
    import sirv_gnrl_xinjector_pkg::*;
#(
    parameter logic [31:0] SEED = XINJ_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] state
);

    localparam lfsr_t SEED_EFF = xinj_seed_fix(SEED);

    lfsr_t state_reg;
    lfsr_t state_next;

    always_comb begin
        state_next = xinj_lfsr_next(state_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SEED_EFF;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/sirv_gnrl_xinjector.sv
// One-entry valid/ready slice that poisons o_dat while not valid and injects random
// upstream stalls. Define XINJ_TRUE_X_EN to drive all-X instead of the LFSR poison.
module sirv_gnrl_xinjector
    import sirv_gnrl_xinjector_pkg::*;
#(
    parameter int          DW        = 32,
    parameter logic [31:0] LFSR_SEED = XINJ_DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    input  logic          cfg_stall_en,
    input  logic [3:0]    cfg_stall_thr,
    output logic [15:0]   stall_cnt
);

    logic [31:0]   lfsr;
    logic          vld_reg;
    logic          vld_next;
    logic [DW-1:0] dat_reg;
    logic [DW-1:0] dat_next;
    logic [15:0]   stall_cnt_reg;
    logic [15:0]   stall_cnt_next;
    logic          stall;
    logic          slot_free;
    logic          push;
    logic          pop;

    sirv_gnrl_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign stall     = cfg_stall_en & (lfsr[3:0] < cfg_stall_thr);
    assign slot_free = ~vld_reg | o_rdy;
    // Ready is held low while reset is asserted so nothing is accepted into a dead slice.
    assign i_rdy     = rst_n & slot_free & ~stall;
    assign push      = i_vld & i_rdy;
    assign pop       = vld_reg & o_rdy;

    always_comb begin
        vld_next       = vld_reg;
        dat_next       = dat_reg;
        stall_cnt_next = stall_cnt_reg;
        if (push) begin
            vld_next = 1'b1;
            dat_next = i_dat;
        end else if (pop) begin
            vld_next = 1'b0;
        end
        if (i_vld & stall & slot_free & (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg       <= 1'b0;
            dat_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            vld_reg       <= vld_next;
            dat_reg       <= dat_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign o_vld     = vld_reg;
    assign stall_cnt = stall_cnt_reg;

`ifdef XINJ_TRUE_X_EN
    assign o_dat = vld_reg ? dat_reg : {DW{1'bx}};
`else
    logic [DW-1:0] poison;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_poison
            assign poison[gi] = xinj_poison_bit(lfsr, gi);
        end
    endgenerate

    assign o_dat = vld_reg ? dat_reg : poison;
`endif

endmodule

// File: tb/tb_sirv_gnrl_xinjector.sv
// Directed bench for sirv_gnrl_xinjector: reset poison sequence, streaming, hold,
// random stalls, counter saturation and asynchronous reset mid-transfer.
module tb_sirv_gnrl_xinjector;

    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vld;
    logic        i_rdy;
    logic [31:0] i_dat;
    logic        o_vld;
    logic        o_rdy;
    logic [31:0] o_dat;
    logic        cfg_stall_en;
    logic [3:0]  cfg_stall_thr;
    logic [15:0] stall_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          n_push   = 0;
    int          n_pop    = 0;
    logic [31:0] m_lfsr;
    logic [15:0] m_cnt;
    logic [31:0] sb[$];
    logic [31:0] poison_tbl [4];

    always #5 clk = ~clk;

    sirv_gnrl_xinjector #(
        .DW        (32),
        .LFSR_SEED (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vld         (i_vld),
        .i_rdy         (i_rdy),
        .i_dat         (i_dat),
        .o_vld         (o_vld),
        .o_rdy         (o_rdy),
        .o_dat         (o_dat),
        .cfg_stall_en  (cfg_stall_en),
        .cfg_stall_thr (cfg_stall_thr),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Expected poison (or all-X) for an idle output.
    task automatic check_idle_dat(input string tag, input logic [31:0] lfsr_val);
`ifdef XINJ_TRUE_X_EN
        check(tag, {32'h0, o_dat}, {32'h0, {32{1'bx}}});
`else
        check(tag, {32'h0, o_dat}, {32'h0, lfsr_val});
`endif
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic step();
        logic exp_vld;
        logic exp_stall;
        logic exp_rdy;
        #1;
        exp_vld   = (sb.size() != 0);
        exp_stall = cfg_stall_en && (m_lfsr[3:0] < cfg_stall_thr);
        exp_rdy   = (!exp_vld || o_rdy) && !exp_stall;
        check("o_vld", {63'h0, o_vld}, {63'h0, exp_vld});
        check("i_rdy", {63'h0, i_rdy}, {63'h0, exp_rdy});
        check("stall_cnt", {48'h0, stall_cnt}, {48'h0, m_cnt});
        if (exp_vld) check("o_dat", {32'h0, o_dat}, {32'h0, sb[0]});
        else         check_idle_dat("o_dat_idle", m_lfsr);
        if (i_vld && exp_stall && (!exp_vld || o_rdy) && m_cnt != 16'hFFFF) m_cnt++;
        if (exp_vld && o_rdy) begin
            void'(sb.pop_front());
            n_pop++;
        end
        if (i_vld && exp_rdy) begin
            sb.push_back(i_dat);
            n_push++;
        end
        @(posedge clk);
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
    endtask

    initial begin
        poison_tbl[0] = 32'hACE1_1234;
        poison_tbl[1] = 32'h5670_891A;
        poison_tbl[2] = 32'h2B38_448D;
        poison_tbl[3] = 32'h95BC_2245;

        rst_n = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
        cfg_stall_en = 1'b0; cfg_stall_thr = 4'd0;
        m_lfsr = SEED; m_cnt = '0;
        repeat (3) @(negedge clk);

        // Held in reset.
        check("rst_o_vld", {63'h0, o_vld}, 64'h0);
        check("rst_i_rdy", {63'h0, i_rdy}, 64'h0);
        check("rst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        check_idle_dat("rst_o_dat", SEED);
        $display("phase reset: checks=%0d", checks);

        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifndef XINJ_TRUE_X_EN
            check("poison_seq", {32'h0, o_dat}, {32'h0, poison_tbl[k]});
`endif
            step();
        end
        $display("phase poison_seq: checks=%0d", checks);

        // Back-to-back stream, no stalls.
        o_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_vld = 1'b1;
            i_dat = 32'h1000_0000 + k;
            step();
        end
        i_vld = 1'b0;
        step();
        check("stream_beats", 64'(n_pop), 64'd100);
        check("stream_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        $display("phase stream: pushed=%0d popped=%0d", n_push, n_pop);

        // Hold one beat against back-pressure, then pop+push in the same cycle.
        o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'hDEAD_BEEF;
        step();
        i_dat = 32'hCAFE_F00D;
        repeat (10) step();
        #1;
        check("hold_o_dat", {32'h0, o_dat}, {32'h0, 32'hDEAD_BEEF});
        check("hold_i_rdy", {63'h0, i_rdy}, 64'h0);
        o_rdy = 1'b1;
        step();
        i_vld = 1'b0;
        #1;
        check("pass_o_dat", {32'h0, o_dat}, {32'h0, 32'hCAFE_F00D});
        step();
        step();
        $display("phase hold: pushed=%0d popped=%0d", n_push, n_pop);

        // Random stalls: threshold 0 then 15 with continuous valid.
        cfg_stall_en = 1'b1;
        cfg_stall_thr = 4'd0;
        for (int k = 0; k < 1000; k++) begin
            i_vld = 1'b1;
            i_dat = 32'h2000_0000 + k;
            step();
        end
        check("thr0_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        cfg_stall_thr = 4'd15;
        for (int k = 0; k < 1000; k++) begin
            i_vld = 1'b1;
            i_dat = 32'h3000_0000 + k;
            step();
        end
        i_vld = 1'b0;
        cfg_stall_en = 1'b0;
        step();
        step();
        check("stall_beats", 64'(n_pop + sb.size()), 64'(n_push));
        check("thr15_stall_cnt", {48'h0, stall_cnt}, {48'h0, m_cnt});
        $display("phase stall: stall_cnt=%0d model=%0d", stall_cnt, m_cnt);

        // Drive the counter past its maximum.
        cfg_stall_en = 1'b1;
        cfg_stall_thr = 4'd15;
        for (int k = 0; k < 72000; k++) begin
            i_vld = 1'b1;
            i_dat = 32'h4000_0000 + k;
            step();
        end
        #1;
        check("sat_stall_cnt", {48'h0, stall_cnt}, 64'hFFFF);
        $display("phase saturate: stall_cnt=%0h", stall_cnt);

        // Asynchronous reset while a beat is held.
        cfg_stall_en = 1'b0;
        o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'h55AA_55AA;
        step();
        i_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_o_vld", {63'h0, o_vld}, 64'h0);
        check("arst_i_rdy", {63'h0, i_rdy}, 64'h0);
        check("arst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        check_idle_dat("arst_o_dat", SEED);
        sb.delete();
        m_lfsr = SEED;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        o_rdy = 1'b1;
        repeat (3) step();
        $display("phase async_reset: checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
